conv_frame_ctrl: RTL and testbench
==================================

Name: conv_frame_ctrl

Overview:
Frame sequencer for the 8-bit streaming convolution unit. On `start` it:
- flushes the unit;
- streams one IMG_W x IMG_H frame from a pixel RAM into the unit;
- collects every valid result into an output RAM;
- reports completion or error.

It sits between the pixel/result memories and the convolution datapath, replacing file-driven stimulus in system use.

Parameters:
- DATA_WIDTH, 8, pixel and result width.
- IMG_W, 100, frame width in pixels.
- IMG_H, 103, frame height in pixels.
- KERNEL, 3, kernel size. Expected output count N_OUT = (IMG_W-KERNEL+1)*(IMG_H-KERNEL+1).
- DRAIN_TIMEOUT, 1024, maximum DRAIN cycles without reaching N_OUT.

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  synchronous active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- busy  out  1  high from INIT through DONE
- done  out  1  one-cycle pulse at frame end
- err  out  1  sticky error; cleared on accepted start
- rd_en  out  1  pixel RAM read strobe
- rd_addr  out  ADDR_W  pixel address; ADDR_W = clog2(IMG_W*IMG_H)
- rd_data  in  DATA_WIDTH  pixel RAM data, valid 1 cycle after rd_en
- conv_Rst  out  1  active-low flush to convolution unit
- conv_data_in  out  DATA_WIDTH  equals rd_data
- conv_valid_in  out  1  rd_en delayed one cycle
- conv_data_out  in  DATA_WIDTH  result from unit
- conv_valid_out  in  1  result valid
- wr_en  out  1  result RAM write strobe
- wr_addr  out  OADDR_W  result address; OADDR_W = clog2(N_OUT)
- wr_data  out  DATA_WIDTH  result data
- out_count  out  OADDR_W+1  results written this frame

Behaviour:
- Reset (Rst=0 at posedge):
  - state IDLE; all counters 0.
  - busy, done, err, rd_en, conv_valid_in, wr_en = 0.
  - conv_Rst = 0 while Rst=0.
- IDLE:
  - conv_Rst=1.
  - start=1 → INIT; clears err, out_count, rd_addr, drain counter.
- INIT (exactly 1 cycle): conv_Rst=0, rd_en=0 → STREAM.
- STREAM:
  - rd_en=1 every cycle; rd_addr increments after each issue.
  - After issuing address IMG_W*IMG_H-1 → DRAIN, with rd_en=0 in DRAIN.
  - No wrap of rd_addr.
- conv_valid_in: register of rd_en; first assert is the cycle after the first STREAM cycle. conv_data_in = rd_data combinationally.
- Write path:
  - conv_valid_out=1 in STREAM or DRAIN → next cycle wr_en=1, wr_data=conv_data_out, wr_addr=out_count; out_count increments.
  - Latency 1 cycle.
  - conv_valid_out in IDLE/INIT/DONE is ignored.
- Overflow: conv_valid_out when out_count==N_OUT → not written, err=1.
- DRAIN:
  - Drain counter increments each cycle.
  - out_count==N_OUT → DONE.
  - Drain counter == DRAIN_TIMEOUT-1 with out_count<N_OUT → err=1, DONE.
  - If both conditions hold in the same cycle, completion wins and err is unchanged.
- DONE (1 cycle): done=1, busy=1 → IDLE.
- start while busy: ignored, no error.
- Reset mid-frame: immediate return to IDLE; partial writes stand; no done pulse.

Optional Feature:
- Macro: CONV_FRAME_CTRL_PAUSE_EN.
- With the macro:
  - An extra input `pause` (1 bit) exists.
  - pause=1 in STREAM suppresses rd_en and holds rd_addr that cycle, so conv_valid_in drops one cycle later.
  - Write path and DRAIN are unaffected.
  - pause is ignored in all other states.
- Without the macro: no `pause` port; STREAM issues one read every cycle.

Decomposition:
- Package conv_ctrl_pkg:
  - state encoding: IDLE, INIT, STREAM, DRAIN, DONE;
  - constant functions for N_PIX, N_OUT, ADDR_W, OADDR_W.
- One sub-module, conv_out_writer: the write register, out_count, and overflow detection. The FSM, read addressing and drain timer remain in conv_frame_ctrl.

Test Plan:
1. Reset then start pulse:
   - conv_Rst low exactly 1 cycle.
   - rd_en high for 10300 consecutive cycles, addresses 0..10299.
   - conv_valid_in lags rd_en by 1 cycle.
2. Model ConvUnit emitting 9898 results:
   - wr_addr 0..9897 in order; wr_data matches with 1-cycle latency.
   - done pulses once; err=0; out_count=9898.
3. Model emitting only 9000 results:
   - After 1024 DRAIN cycles, done=1 and err=1; out_count=9000.
4. Model emitting 9899 results:
   - The 9899th is not written; err=1; out_count=9898.
5. Start held high during STREAM and Rst=0 mid-frame:
   - Start is ignored during STREAM.
   - Reset returns to IDLE, busy=0, no done pulse; a new start restarts from address 0.
6. With CONV_FRAME_CTRL_PAUSE_EN, pause high for 5 cycles at address 500:
   - rd_addr holds at 500 for 5 cycles.
   - Total rd_en count is still 10300.

Source files
------------

// File: rtl/conv_ctrl_pkg.sv
// Shared state encoding and frame geometry helpers for the convolution frame sequencer.
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic int unsigned n_pix(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

  function automatic int unsigned n_out(input int unsigned w, input int unsigned h,
                                        input int unsigned k);
    return (w - k + 1) * (h - k + 1);
  endfunction

  // Bit width able to index n items; never below 1 so degenerate frames still elaborate.
  function automatic int unsigned width_of(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned addr_w(input int unsigned w, input int unsigned h);
    return width_of(n_pix(w, h));
  endfunction

  function automatic int unsigned oaddr_w(input int unsigned w, input int unsigned h,
                                          input int unsigned k);
    return width_of(n_out(w, h, k));
  endfunction

endpackage

// File: rtl/conv_out_writer.sv
// Result write register for the frame sequencer: captures unit results into the
// output RAM, counts them, and flags results that arrive once the frame is full.
module conv_out_writer
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OADDR_W    = 14,
  parameter int unsigned N_OUT      = 9898
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  accept,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  wr_en,
  output logic [OADDR_W-1:0]    wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [OADDR_W:0]      out_count,
  output logic                  full_c,
  output logic                  ovf_c
);

  localparam logic [OADDR_W:0] FULL = (OADDR_W + 1)'(N_OUT);

  logic                  wr_en_q, wr_en_d;
  logic [OADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [OADDR_W:0]      out_count_q, out_count_d;
  logic                  take_c;

  always_comb begin
    full_c      = (out_count_q == FULL);
    take_c      = accept & valid_in;
    ovf_c       = take_c & full_c;
    wr_en_d     = take_c & ~full_c;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    out_count_d = out_count_q;
    if (clear) begin
      out_count_d = '0;
    end else if (wr_en_d) begin
      wr_addr_d   = out_count_q[OADDR_W-1:0];
      wr_data_d   = data_in;
      out_count_d = out_count_q + (OADDR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      out_count_q <= '0;
    end else begin
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign out_count = out_count_q;

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer: flushes the convolution unit, streams one frame from pixel RAM,
// collects results into the output RAM. CONV_FRAME_CTRL_PAUSE_EN adds a read-pause input.
module conv_frame_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned IMG_W         = 100,
  parameter int unsigned IMG_H         = 103,
  parameter int unsigned KERNEL        = 3,
  parameter int unsigned DRAIN_TIMEOUT = 1024,
  localparam int unsigned ADDR_W       = addr_w(IMG_W, IMG_H),
  localparam int unsigned OADDR_W      = oaddr_w(IMG_W, IMG_H, KERNEL)
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  start,
`ifdef CONV_FRAME_CTRL_PAUSE_EN
  input  logic                  pause,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  conv_Rst,
  output logic [DATA_WIDTH-1:0] conv_data_in,
  output logic                  conv_valid_in,
  input  logic [DATA_WIDTH-1:0] conv_data_out,
  input  logic                  conv_valid_out,
  output logic                  wr_en,
  output logic [OADDR_W-1:0]    wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [OADDR_W:0]      out_count
);

  localparam int unsigned N_PIX = n_pix(IMG_W, IMG_H);
  localparam int unsigned N_OUT = n_out(IMG_W, IMG_H, KERNEL);
  localparam int unsigned DT_W  = width_of(DRAIN_TIMEOUT);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N_PIX - 1);
  localparam logic [DT_W-1:0]   DRAIN_LAST = DT_W'(DRAIN_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                conv_rst_q, conv_rst_d;
  logic                cvi_q;
  logic [DT_W-1:0]     drain_q, drain_d;
  logic                clear_c;
  logic                accept_c;
  logic                full_c;
  logic                ovf_c;
  logic                pause_c;

`ifdef CONV_FRAME_CTRL_PAUSE_EN
  assign pause_c = pause;
`else
  assign pause_c = 1'b0;
`endif

  assign accept_c = (state_q == ST_STREAM) || (state_q == ST_DRAIN);

  // Next-state, read addressing and drain timer; outputs follow the next state.
  always_comb begin
    state_d   = state_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    drain_d   = drain_q;
    err_d     = err_q | ovf_c;
    clear_c   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_INIT;
          err_d     = 1'b0;
          rd_addr_d = '0;
          drain_d   = '0;
          clear_c   = 1'b1;
        end
      end
      ST_INIT: begin
        state_d = ST_STREAM;
        rd_en_d = 1'b1;
      end
      ST_STREAM: begin
        if (rd_en_q && (rd_addr_q == LAST_ADDR)) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end else begin
          // A paused cycle issues nothing, so the address only moves after a real issue.
          if (rd_en_q) rd_addr_d = rd_addr_q + ADDR_W'(1);
          rd_en_d = ~pause_c;
        end
      end
      ST_DRAIN: begin
        if (full_c) begin
          state_d = ST_DONE;
        end else if (drain_q == DRAIN_LAST) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          drain_d = drain_q + DT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    conv_rst_d = (state_d != ST_INIT);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      conv_rst_q <= 1'b0;
      cvi_q      <= 1'b0;
      drain_q    <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      conv_rst_q <= conv_rst_d;
      cvi_q      <= rd_en_q;
      drain_q    <= drain_d;
    end
  end

  conv_out_writer #(
    .DATA_WIDTH (DATA_WIDTH),
    .OADDR_W    (OADDR_W),
    .N_OUT      (N_OUT)
  ) u_writer (
    .clk       (Clk),
    .rst_n     (Rst),
    .clear     (clear_c),
    .accept    (accept_c),
    .valid_in  (conv_valid_out),
    .data_in   (conv_data_out),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .out_count (out_count),
    .full_c    (full_c),
    .ovf_c     (ovf_c)
  );

  // The flush must reach the unit during the reset cycle itself, not one edge later.
  assign conv_Rst      = conv_rst_q & Rst;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign rd_en         = rd_en_q;
  assign rd_addr       = rd_addr_q;
  assign conv_valid_in = cvi_q;
  assign conv_data_in  = rd_data;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Self-checking bench for conv_frame_ctrl: pixel RAM model, a behavioural convolution
// unit that emits a configurable number of results, and a write scoreboard.
module tb_conv_frame_ctrl;

  localparam int unsigned IMG_W   = 100;
  localparam int unsigned IMG_H   = 103;
  localparam int unsigned KERNEL  = 3;
  localparam int unsigned N_PIX   = IMG_W * IMG_H;
  localparam int unsigned N_OUT   = (IMG_W - KERNEL + 1) * (IMG_H - KERNEL + 1);
  localparam int unsigned ADDR_W  = $clog2(N_PIX);
  localparam int unsigned OADDR_W = $clog2(N_OUT);
  localparam int unsigned LAT     = 3;

  logic               Clk = 1'b0;
  logic               Rst = 1'b0;
  logic               start = 1'b0;
`ifdef CONV_FRAME_CTRL_PAUSE_EN
  logic               pause = 1'b0;
`endif
  logic               busy, done, err, rd_en, conv_Rst, conv_valid_in, wr_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic [7:0]         rd_data = 8'h00;
  logic [7:0]         conv_data_in;
  logic [7:0]         conv_data_out = 8'h00;
  logic               conv_valid_out = 1'b0;
  logic [OADDR_W-1:0] wr_addr;
  logic [7:0]         wr_data;
  logic [OADDR_W:0]   out_count;

  conv_frame_ctrl dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .start          (start),
`ifdef CONV_FRAME_CTRL_PAUSE_EN
    .pause          (pause),
`endif
    .busy           (busy),
    .done           (done),
    .err            (err),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .conv_Rst       (conv_Rst),
    .conv_data_in   (conv_data_in),
    .conv_valid_in  (conv_valid_in),
    .conv_data_out  (conv_data_out),
    .conv_valid_out (conv_valid_out),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .out_count      (out_count)
  );

  initial forever #5 Clk = ~Clk;

  typedef struct {
    int unsigned addr;
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  typedef struct {
    int unsigned n_emit;
    bit          hold_start;
    bit          use_pause;
    int unsigned exp_cnt;
    bit          exp_err;
    int          exp_drain;
  } vec_t;

  exp_t        exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  int unsigned sb_bad = 0;
  int unsigned wr_seen = 0;

  // Conv unit model state
  int unsigned    n_emit = 0;
  int unsigned    m_pix = 0, m_tok = 0, m_out = 0;
  logic [LAT-1:0] pipe = '0;
  logic           p_cvi = 1'b0, p_conv_rst = 1'b0, p_rd_en = 1'b0;
  logic [ADDR_W-1:0] p_rd_addr = '0;

  function automatic logic [7:0] pix(input int unsigned a);
    return 8'(a * 13 + 5);
  endfunction

  function automatic bit qualify(input int unsigned idx);
    return ((idx % IMG_W) >= KERNEL - 1) && ((idx / IMG_W) >= KERNEL - 1);
  endfunction

  task automatic check(input string name, input longint unsigned act, input longint unsigned want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic model_flush();
    pipe = '0; m_pix = 0; m_tok = 0; m_out = 0;
    conv_valid_out = 1'b0;
  endtask

  // One clock: RAM read, write scoreboard, conv unit model, then next-cycle inputs.
  task automatic step();
    exp_t        e;
    logic        tok, vout;
    int unsigned idx;
    @(posedge Clk);
    #1;
    cyc++;
    if (p_rd_en) rd_data = pix(32'(p_rd_addr));
    p_rd_en = rd_en;
    p_rd_addr = rd_addr;
    #1;
    if (conv_valid_in && (conv_data_in !== rd_data)) sb_bad++;
    if (wr_en) begin
      wr_seen++;
      if (exp_q.size() == 0) sb_bad++;
      else begin
        e = exp_q.pop_front();
        if (wr_addr != OADDR_W'(e.addr) || wr_data != e.data || cyc != e.cyc + 1) sb_bad++;
      end
    end
    tok = 1'b0;
    vout = 1'b0;
    if (!p_conv_rst) model_flush();
    else begin
      if (p_cvi) begin
        idx = m_pix;
        m_pix++;
        tok = qualify(idx) && (m_tok < n_emit);
      end else begin
        tok = (m_pix == N_PIX) && (m_tok < n_emit);
      end
      if (tok) m_tok++;
      vout = pipe[LAT-1];
      pipe = {pipe[LAT-2:0], tok};
    end
    conv_valid_out = vout;
    if (vout) begin
      conv_data_out = 8'(m_out * 7 + 3);
      if (m_out < N_OUT) exp_q.push_back('{m_out, conv_data_out, cyc});
      m_out++;
    end
    p_cvi = conv_valid_in;
    p_conv_rst = conv_Rst;
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int unsigned rd_cnt = 0, addr_bad = 0, lag_bad = 0, rst_low = 0, done_cnt = 0;
    int unsigned drain_steps = 0, hold_steps = 0, steps = 0;
    bit          prev_rd_en = 1'b0, fin = 1'b0;
`ifdef CONV_FRAME_CTRL_PAUSE_EN
    int          pause_left = 0;
    bit          pause_done = 1'b0;
`endif
    n_emit = v.n_emit;
    model_flush();
    exp_q.delete();
    sb_bad = 0;
    wr_seen = 0;
    start = 1'b1;
    step();
    check({tag, "/init_busy"}, busy, 1);
    check({tag, "/init_err_cleared"}, err, 0);
    while (!fin && steps < 20000) begin
      if (!v.hold_start || steps >= 2000) start = 1'b0;
      if (!conv_Rst) rst_low++;
      if (conv_valid_in !== prev_rd_en) lag_bad++;
      prev_rd_en = rd_en;
      if (rd_en) begin
        if (rd_addr != ADDR_W'(rd_cnt)) addr_bad++;
        rd_cnt++;
      end else if (busy && rd_cnt == N_PIX && !done) drain_steps++;
      if (!rd_en && busy && rd_cnt == 500 && rd_addr == ADDR_W'(500)) hold_steps++;
      if (done) begin
        done_cnt++;
        fin = 1'b1;
      end
`ifdef CONV_FRAME_CTRL_PAUSE_EN
      if (pause_left > 0) begin
        pause_left--;
        pause = (pause_left != 0);
      end else if (v.use_pause && !pause_done && rd_en && rd_addr == ADDR_W'(499)) begin
        pause = 1'b1;
        pause_left = 5;
        pause_done = 1'b1;
      end
`endif
      step();
      steps++;
    end
    start = 1'b0;
    check({tag, "/done_seen"}, fin, 1);
    check({tag, "/busy_after_done"}, busy, 0);
    for (int i = 0; i < 4; i++) begin
      if (done) done_cnt++;
      step();
    end
    check({tag, "/done_pulses"}, done_cnt, 1);
    check({tag, "/out_count"}, out_count, v.exp_cnt);
    check({tag, "/err"}, err, v.exp_err);
    check({tag, "/rd_en_count"}, rd_cnt, N_PIX);
    check({tag, "/addr_seq_errs"}, addr_bad, 0);
    check({tag, "/valid_in_lag_errs"}, lag_bad, 0);
    check({tag, "/conv_rst_low_cycles"}, rst_low, 1);
    check({tag, "/write_sb_errs"}, sb_bad, 0);
    check({tag, "/writes"}, wr_seen, v.exp_cnt);
    check({tag, "/unwritten"}, exp_q.size(), 0);
    check({tag, "/pause_hold_cycles"}, hold_steps, v.use_pause ? 5 : 0);
    if (v.exp_drain >= 0) check({tag, "/drain_cycles"}, drain_steps, 32'(v.exp_drain));
  endtask

  initial begin
    vec_t        vecs[4];
    vec_t        r;
    int unsigned n_vecs;
    int unsigned dcnt;

    vecs[0] = '{n_emit: N_OUT,     hold_start: 1'b1, use_pause: 1'b0, exp_cnt: N_OUT, exp_err: 1'b0, exp_drain: -1};
    vecs[1] = '{n_emit: 9000,      hold_start: 1'b0, use_pause: 1'b0, exp_cnt: 9000,  exp_err: 1'b1, exp_drain: 1024};
    vecs[2] = '{n_emit: N_OUT + 1, hold_start: 1'b0, use_pause: 1'b0, exp_cnt: N_OUT, exp_err: 1'b1, exp_drain: -1};
    n_vecs = 3;
`ifdef CONV_FRAME_CTRL_PAUSE_EN
    vecs[3] = '{n_emit: N_OUT,     hold_start: 1'b0, use_pause: 1'b1, exp_cnt: N_OUT, exp_err: 1'b0, exp_drain: -1};
    n_vecs = 4;
`endif

    // Reset state
    Rst = 1'b0;
    repeat (3) step();
    check("rst/busy", busy, 0);
    check("rst/done", done, 0);
    check("rst/err", err, 0);
    check("rst/rd_en", rd_en, 0);
    check("rst/conv_valid_in", conv_valid_in, 0);
    check("rst/wr_en", wr_en, 0);
    check("rst/out_count", out_count, 0);
    check("rst/conv_Rst", conv_Rst, 0);
    Rst = 1'b1;
    step();
    check("idle/conv_Rst", conv_Rst, 1);
    check("idle/busy", busy, 0);

    for (int i = 0; i < int'(n_vecs); i++) begin
      run_frame(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of a frame, then restart from address 0
    n_emit = N_OUT;
    model_flush();
    exp_q.delete();
    sb_bad = 0;
    dcnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (600) begin
      if (done) dcnt++;
      step();
    end
    check("midrst/write_sb_errs", sb_bad, 0);
    Rst = 1'b0;
    step();
    check("midrst/busy", busy, 0);
    check("midrst/done", done, 0);
    check("midrst/rd_en", rd_en, 0);
    check("midrst/conv_valid_in", conv_valid_in, 0);
    check("midrst/wr_en", wr_en, 0);
    check("midrst/conv_Rst", conv_Rst, 0);
    check("midrst/out_count", out_count, 0);
    step();
    Rst = 1'b1;
    model_flush();
    exp_q.delete();
    repeat (3) begin
      if (done) dcnt++;
      step();
    end
    check("midrst/no_done", dcnt, 0);
    check("midrst/idle_busy", busy, 0);
    r = vecs[0];
    r.hold_start = 1'b0;
    run_frame(r, "restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
